// File: rtl/pc_sequencer_if.sv
// Fetch/commit bus between the PC sequencer and its environment.
// The sequencer takes the slave view; whoever drives pcsrc and memory readiness is the master.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  logic [1:0]      pcsrc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] alu_result;
  logic            stall;
  logic            imem_ready;
  logic            fetch_req;
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            misalign;
  logic [XLEN-1:0] epc;
  logic [31:0]     retire_cnt;

  modport master (
    output pcsrc, imm, alu_result, stall, imem_ready,
    input  fetch_req, instr_valid, pc, pc_plus4, misalign, epc, retire_cnt
  );

  modport slave (
    input  pcsrc, imm, alu_result, stall, imem_ready,
    output fetch_req, instr_valid, pc, pc_plus4, misalign, epc, retire_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch/commit handshake, next-PC selection and
// redirection of misaligned control-flow targets to the trap vector.
module pc_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = 'h100
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    COMMIT,
    TRAP
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic [31:0]     r_retire_cnt;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic            w_fetch_req;
  logic            w_instr_valid;
  logic            w_misalign;

  assign w_pc_plus4 = r_pc + XLEN'(4);

  // JALR clears bit0 only, so a target with bit1 set still traps below.
  always_comb begin
    w_target = w_pc_plus4;
    case (bus.pcsrc)
      2'b00:   w_target = w_pc_plus4;
      2'b01:   w_target = r_pc + bus.imm;
      2'b10:   w_target = bus.alu_result & ~XLEN'(1);
      default: w_target = TRAP_VEC;
    endcase
  end

  assign w_misaligned = (bus.pcsrc != 2'b11) && (w_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_fetch_req   = 1'b0;
    w_instr_valid = 1'b0;
    w_misalign    = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_state = FETCH;
      end
      FETCH: begin
        w_fetch_req = 1'b1;
        if (bus.imem_ready) begin
          w_next_state = COMMIT;
        end
      end
      COMMIT: begin
        w_instr_valid = 1'b1;
        if (!bus.stall) begin
          w_next_state = w_misaligned ? TRAP : FETCH;
        end
      end
      TRAP: begin
        w_misalign   = 1'b1;
        w_next_state = FETCH;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // The faulting PC is captured on the way into TRAP; pc moves to the vector one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_epc        <= '0;
      r_retire_cnt <= '0;
    end else begin
      case (r_state)
        COMMIT: begin
          if (!bus.stall) begin
            if (w_misaligned) begin
              r_epc <= r_pc;
            end else begin
              r_pc         <= w_target;
              r_retire_cnt <= r_retire_cnt + 32'd1;
            end
          end
        end
        TRAP: begin
          r_pc <= TRAP_VEC;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.fetch_req   = w_fetch_req;
  assign bus.instr_valid = w_instr_valid;
  assign bus.misalign    = w_misalign;
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.epc         = r_epc;
  assign bus.retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Instruction-level bench for pc_sequencer: each instruction is fetched, optionally
// stalled and committed, and the outcome is compared to an arithmetic model of the PC.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_sequencer_if #(.XLEN(32)) bus ();

  pc_sequencer #(
    .XLEN     (32),
    .RESET_PC (RESET_PC),
    .TRAP_VEC (TRAP_VEC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int testsRun  = 0;
  int failCount = 0;

  // Architectural view: where the next commit must be, how many retired, last fault PC.
  logic [31:0] mPc;
  logic [31:0] mRetire;
  logic [31:0] mEpc;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] refTarget(input logic [31:0] pc, input logic [1:0] sel,
                                            input logic [31:0] imm, input logic [31:0] alu);
    case (sel)
      2'b00:   return pc + 32'd4;
      2'b01:   return pc + imm;
      2'b10:   return {alu[31:1], 1'b0};
      default: return TRAP_VEC;
    endcase
  endfunction

  // Asserts reset at the current negedge so the state being interrupted is the one in progress.
  task automatic doReset(input int cycles);
    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.imem_ready = 1'($urandom);
    repeat (cycles) @(negedge clk);
    checkOutput("resetPc", bus.pc, RESET_PC);
    checkOutput("resetFetchReq", 32'(bus.fetch_req), 32'd0);
    checkOutput("resetInstrValid", 32'(bus.instr_valid), 32'd0);
    checkOutput("resetMisalign", 32'(bus.misalign), 32'd0);
    checkOutput("resetEpc", bus.epc, 32'd0);
    checkOutput("resetRetire", bus.retire_cnt, 32'd0);
    rst     = 1'b0;
    mPc     = RESET_PC;
    mRetire = 32'd0;
    mEpc    = 32'd0;
    @(negedge clk);
    checkOutput("firstFetchAfterReset", 32'(bus.fetch_req), 32'd1);
  endtask

  // One instruction: wait for fetch, hold memory off, commit after stalls with the given select.
  task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] alu,
                               input int stallCycles, input int readyDelay);
    int          waitCount;
    logic [31:0] target;
    logic        trap;
    waitCount = 0;
    while (bus.fetch_req !== 1'b1 && waitCount < 20) begin
      bus.imem_ready = 1'($urandom);
      bus.pcsrc      = 2'($urandom);
      bus.stall      = 1'($urandom);
      @(negedge clk);
      waitCount++;
    end
    if (bus.fetch_req !== 1'b1) begin
      checkOutput("fetchTimeout", 32'd0, 32'd1);
      return;
    end
    checkOutput("fetchPc", bus.pc, mPc);
    checkOutput("fetchNoMisalign", 32'(bus.misalign), 32'd0);
    for (int i = 0; i < readyDelay; i++) begin
      bus.imem_ready = 1'b0;
      @(negedge clk);
      checkOutput("fetchHeld", 32'(bus.fetch_req), 32'd1);
      checkOutput("fetchPcStable", bus.pc, mPc);
    end
    bus.imem_ready = 1'b1;
    bus.stall      = 1'b1;
    @(negedge clk);
    checkOutput("commitValid", 32'(bus.instr_valid), 32'd1);
    checkOutput("commitNoReq", 32'(bus.fetch_req), 32'd0);
    checkOutput("commitPc", bus.pc, mPc);
    checkOutput("commitPcPlus4", bus.pc_plus4, mPc + 32'd4);
    checkOutput("commitRetire", bus.retire_cnt, mRetire);
    checkOutput("commitEpc", bus.epc, mEpc);
    for (int s = 0; s < stallCycles; s++) begin
      bus.stall      = 1'b1;
      bus.pcsrc      = 2'b10;
      bus.alu_result = $urandom | 32'h2;
      bus.imem_ready = 1'($urandom);
      @(negedge clk);
      checkOutput("stallValid", 32'(bus.instr_valid), 32'd1);
      checkOutput("stallPc", bus.pc, mPc);
      checkOutput("stallRetire", bus.retire_cnt, mRetire);
      checkOutput("stallNoTrap", 32'(bus.misalign), 32'd0);
    end
    bus.stall      = 1'b0;
    bus.pcsrc      = sel;
    bus.imm        = imm;
    bus.alu_result = alu;
    target = refTarget(mPc, sel, imm, alu);
    trap   = (sel != 2'b11) && (target % 4 != 0);
    @(negedge clk);
    bus.imm        = $urandom;
    bus.alu_result = $urandom;
    if (trap) begin
      mEpc = mPc;
      mPc  = TRAP_VEC;
      checkOutput("trapMisalign", 32'(bus.misalign), 32'd1);
      checkOutput("trapEpc", bus.epc, mEpc);
      checkOutput("trapRetire", bus.retire_cnt, mRetire);
    end else begin
      mPc = target;
      mRetire++;
      checkOutput("nextNoMisalign", 32'(bus.misalign), 32'd0);
      checkOutput("nextFetchReq", 32'(bus.fetch_req), 32'd1);
      checkOutput("nextPc", bus.pc, mPc);
      checkOutput("nextRetire", bus.retire_cnt, mRetire);
      checkOutput("nextEpc", bus.epc, mEpc);
    end
  endtask

  initial begin
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] alu;
    bus.pcsrc      = 2'b00;
    bus.imm        = '0;
    bus.alu_result = '0;
    bus.stall      = 1'b0;
    bus.imem_ready = 1'b0;
    @(negedge clk);
    doReset(2);

    for (int i = 0; i < 4; i++) applyStimulus(2'b00, 32'd0, 32'd0, 0, 0);
    checkOutput("seqRetire4", bus.retire_cnt, 32'd4);
    checkOutput("seqPc10", bus.pc, 32'h10);

    applyStimulus(2'b10, 32'd0, 32'h20, 0, 0);
    applyStimulus(2'b01, 32'hFFFF_FFF0, 32'd0, 0, 1);
    checkOutput("branchBackPc", bus.pc, 32'h10);

    applyStimulus(2'b10, 32'd0, 32'h40, 0, 0);
    applyStimulus(2'b10, 32'd0, 32'h83, 0, 0);
    checkOutput("jalrTrapEpc", bus.epc, 32'h40);
    applyStimulus(2'b10, 32'd0, 32'h40, 0, 0);
    applyStimulus(2'b10, 32'd0, 32'h85, 0, 0);
    checkOutput("jalrOddPc", bus.pc, 32'h84);

    applyStimulus(2'b00, 32'd0, 32'd0, 3, 5);

    applyStimulus(2'b10, 32'd0, 32'hFFFF_FFFC, 0, 0);
    applyStimulus(2'b00, 32'd0, 32'd0, 0, 0);
    checkOutput("wrapPc", bus.pc, 32'd0);
    applyStimulus(2'b11, 32'd0, 32'd3, 0, 0);
    checkOutput("trapVecPc", bus.pc, TRAP_VEC);

    for (int n = 0; n < 200; n++) begin
      sel = 2'($urandom_range(0, 3));
      imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      alu = ($urandom_range(0, 3) == 0) ? $urandom : (($urandom & 32'hFFFF_FFFC) | ($urandom & 32'h1));
      applyStimulus(sel, imm, alu, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    applyStimulus(2'b10, 32'd0, 32'h202, 0, 0);
    applyStimulus(2'b00, 32'd0, 32'd0, 0, 0);
    waitFetchAndReset();

    applyStimulus(2'b10, 32'd0, 32'h3A, 0, 0);
    doReset(1);
    applyStimulus(2'b00, 32'd0, 32'd0, 0, 0);
    checkOutput("afterResetPc", bus.pc, 32'd4);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  // Parks the sequencer in FETCH with memory not ready, then resets it there.
  task automatic waitFetchAndReset();
    int waitCount;
    waitCount = 0;
    while (bus.fetch_req !== 1'b1 && waitCount < 20) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput("midFetchReached", 32'(bus.fetch_req), 32'd1);
    bus.imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    doReset(1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and consumes the resolved `pcsrc` produced by the branch-resolution logic.
- Computes the next PC for each case: sequential, branch/JAL target, JALR target, or trap vector.
- Fetch to instruction memory uses a request/ready handshake. Each instruction is held in a commit cycle, and `stall` can extend that cycle.
- Detects misaligned control-flow targets, redirects them to the trap vector, and records the faulting PC.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or on `pcsrc`=2'b11.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pcsrc  in  2  resolved PC select: 00 = PC+4, 01 = PC+imm, 10 = (alu_result & ~1), 11 = TRAP_VEC.
- imm  in  XLEN  sign-extended branch/JAL offset.
- alu_result  in  XLEN  JALR sum rs1+imm.
- stall  in  1  hold current instruction in commit.
- imem_ready  in  1  instruction memory has instruction for `pc`.
- fetch_req  out  1  fetch request for `pc`.
- instr_valid  out  1  instruction at `pc` is in commit this cycle.
- pc  out  XLEN  current PC.
- pc_plus4  out  XLEN  pc+4 modulo 2^XLEN (combinational from `pc`).
- misalign  out  1  one-cycle pulse when a trap is taken for a misaligned target.
- epc  out  XLEN  PC of the instruction whose target was misaligned.
- retire_cnt  out  32  count of instructions retired.

Behaviour:
- Reset values, applied on any clock edge with rst=1 in any state, including mid-fetch: state=IDLE, pc=RESET_PC, fetch_req=0, instr_valid=0, misalign=0, epc=0, retire_cnt=0.
- States:
  - IDLE: one cycle with no request, then always go to FETCH.
  - FETCH: fetch_req=1, pc stable. imem_ready=1 -> COMMIT next cycle; otherwise remain. A fetch takes 1 cycle minimum from request to commit.
  - COMMIT: instr_valid=1, fetch_req=0.
    - stall=1: remain in COMMIT, pc unchanged, nothing retired. stall takes priority over every other event, including a misaligned target.
    - stall=0: compute target T from pcsrc. If pcsrc≠11 and T[1:0]≠00, go to TRAP. Otherwise pc<=T, retire_cnt+=1, go to FETCH.
  - TRAP: single cycle. misalign=1, epc holds the committing PC (latched on the COMMIT->TRAP edge), pc<=TRAP_VEC, then FETCH. The faulting instruction is not retired.
- Target arithmetic: all sums modulo 2^XLEN and wrap silently. pc=32'hFFFF_FFFC with pcsrc=00 gives pc=0 and no trap.
- JALR target: alu_result with bit0 cleared. Bit1 set still traps.
- pcsrc=11: loads TRAP_VEC directly, counts as retired, misalign stays 0, epc unchanged.
- pcsrc, imm and alu_result are sampled only in COMMIT with stall=0. Their values in other states are ignored.
- imem_ready outside FETCH is ignored.
- epc holds its value until the next misalign trap or reset.
- retire_cnt wraps from 32'hFFFF_FFFF to 0.
- Throughput with imem_ready tied high: one instruction per 2 cycles (FETCH, COMMIT).

Test Plan:
- Reset then sequential: rst=1 for 2 cycles, imem_ready=1, pcsrc=00 -> fetch_req is asserted on the second cycle after rst falls. pc goes 0,4,8,C on successive commits and retire_cnt reaches 4.
- Branch taken and backward: at pc=0x20, pcsrc=01, imm=32'hFFFF_FFF0 -> next commit at pc=0x10, retire_cnt +1, misalign=0.
- JALR and misaligned:
  - pc=0x40, pcsrc=10, alu_result=0x83 -> pc=0x82 is misaligned, so TRAP: misalign pulses 1 cycle, epc=0x40, pc=0x100, retire_cnt unchanged.
  - Same case with alu_result=0x85 -> pc=0x84, no trap.
- Stall and slow memory:
  - stall=1 for 3 cycles in COMMIT -> pc and retire_cnt frozen, instr_valid stays 1, and a misaligned pcsrc during the stall does not trap.
  - imem_ready low for 5 cycles -> fetch_req is held and pc is stable.
- Wrap and trap vector:
  - pc=32'hFFFF_FFFC, pcsrc=00 -> pc=0, no trap.
  - pcsrc=11 -> pc=0x100, retire_cnt +1, misalign=0.
- Reset mid-operation: assert rst while in FETCH with imem_ready=0, and again in TRAP -> the next cycle has pc=RESET_PC, all outputs at reset values, state IDLE, and epc=0.
